// File: rtl/stepper_step_sequencer.sv
// Step/dir/enable sequencer for one stepper driver: emits a fixed-width STEP pulse,
// then waits on an external one-shot delay timer before the next step.
module stepper_step_sequencer #(
  parameter int unsigned STEP_HIGH = 50,
  parameter int unsigned STEPS_W   = 8
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic               cmd_dir,
  input  logic [STEPS_W-1:0] cmd_steps,
  input  logic               abort,
  output logic               timer_start,
  input  logic               timer_done,
  output logic               step,
  output logic               dir,
  output logic               enable,
  output logic               busy,
  output logic [STEPS_W-1:0] steps_left,
  output logic               done,
  output logic               aborted
);

  localparam int unsigned HI_W = 8;
  localparam logic [HI_W-1:0] HI_LOAD = HI_W'(STEP_HIGH - 1);

  typedef enum logic [2:0] {
    IDLE,
    STEP_HI,
    START,
    WAIT,
    FINISH
  } state_t;

  state_t             state, state_d;
  logic [HI_W-1:0]    hi_cnt, hi_cnt_d;
  logic [STEPS_W-1:0] left_d;
  logic               dir_d, step_d, enable_d, timer_start_d, done_d, aborted_d;

  // Next-state and registered-output values
  always_comb begin
    state_d       = state;
    hi_cnt_d      = hi_cnt;
    left_d        = steps_left;
    dir_d         = dir;
    step_d        = step;
    enable_d      = enable;
    timer_start_d = 1'b0;
    done_d        = 1'b0;
    aborted_d     = 1'b0;

    case (state)
      IDLE: begin
        if (cmd_valid && !abort) begin
          dir_d    = cmd_dir;
          left_d   = cmd_steps;
          enable_d = 1'b1;
          if (cmd_steps == '0) begin
            state_d = FINISH;
            done_d  = 1'b1;
          end else begin
            state_d  = STEP_HI;
            step_d   = 1'b1;
            hi_cnt_d = HI_LOAD;
          end
        end
      end
      STEP_HI: begin
        if (hi_cnt == '0) begin
          step_d        = 1'b0;
          timer_start_d = 1'b1;
          state_d       = START;
        end else begin
          hi_cnt_d = hi_cnt - HI_W'(1);
        end
      end
      // timer_done may still be high from the previous delay here, so it is ignored
      START: state_d = WAIT;
      WAIT: begin
        if (timer_done) begin
          if (steps_left <= STEPS_W'(1)) begin
            left_d  = '0;
            state_d = FINISH;
            done_d  = 1'b1;
          end else begin
            left_d   = steps_left - STEPS_W'(1);
            state_d  = STEP_HI;
            step_d   = 1'b1;
            hi_cnt_d = HI_LOAD;
          end
        end
      end
      FINISH: begin
        state_d  = IDLE;
        enable_d = 1'b0;
      end
      default: state_d = IDLE;
    endcase

    // Abort overrides everything, but a move already in FINISH completes normally
    if (abort && (state != IDLE) && (state != FINISH)) begin
      state_d       = IDLE;
      hi_cnt_d      = hi_cnt;
      left_d        = steps_left;
      step_d        = 1'b0;
      enable_d      = 1'b0;
      timer_start_d = 1'b0;
      done_d        = 1'b0;
      aborted_d     = 1'b1;
    end
  end

  // State and output registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      hi_cnt      <= '0;
      steps_left  <= '0;
      dir         <= 1'b0;
      step        <= 1'b0;
      enable      <= 1'b0;
      timer_start <= 1'b0;
      done        <= 1'b0;
      aborted     <= 1'b0;
      busy        <= 1'b0;
      cmd_ready   <= 1'b1;
    end else begin
      state       <= state_d;
      hi_cnt      <= hi_cnt_d;
      steps_left  <= left_d;
      dir         <= dir_d;
      step        <= step_d;
      enable      <= enable_d;
      timer_start <= timer_start_d;
      done        <= done_d;
      aborted     <= aborted_d;
      busy        <= (state_d != IDLE);
      cmd_ready   <= (state_d == IDLE);
    end
  end

endmodule

// File: tb/tb_stepper_step_sequencer.sv
// Self-checking bench for stepper_step_sequencer: directed scenarios plus random
// traffic, compared every cycle against a time-since-step-edge behavioural model.
module tb_stepper_step_sequencer;

  localparam int SH = 50;
  localparam int SW = 8;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_dir = 1'b0;
  logic [SW-1:0] cmd_steps = '0;
  logic          abort = 1'b0;
  logic          timer_done = 1'b0;
  logic          cmd_ready, timer_start, step, dir, enable, busy, done, aborted;
  logic [SW-1:0] steps_left;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clock = ~clock;

  stepper_step_sequencer #(.STEP_HIGH(SH), .STEPS_W(SW)) dut (
    .clock(clock), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_dir(cmd_dir), .cmd_steps(cmd_steps), .abort(abort), .timer_start(timer_start),
    .timer_done(timer_done), .step(step), .dir(dir), .enable(enable), .busy(busy),
    .steps_left(steps_left), .done(done), .aborted(aborted)
  );

  // Model: mode 0 idle, 1 moving, 2 finishing. m_t counts cycles since the current
  // step's rising edge: high while m_t < SH, timer start at m_t == SH, waiting beyond.
  int   m_mode = 0;
  int   m_t = 0;
  int   m_left = 0;
  logic m_dir = 1'b0;
  logic m_en = 1'b0;
  logic m_abt = 1'b0;

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      m_mode = 0; m_t = 0; m_left = 0; m_dir = 1'b0; m_en = 1'b0; m_abt = 1'b0;
    end else begin
      m_abt = 1'b0;
      case (m_mode)
        0: if (cmd_valid && !abort) begin
          m_dir  = cmd_dir;
          m_left = int'(cmd_steps);
          m_en   = 1'b1;
          if (cmd_steps == '0) m_mode = 2;
          else begin m_mode = 1; m_t = 0; end
        end
        1: if (abort) begin
          m_mode = 0; m_en = 1'b0; m_abt = 1'b1;
        end else if (m_t <= SH || !timer_done) begin
          m_t = m_t + 1;
        end else begin
          m_left = m_left - 1;
          if (m_left == 0) m_mode = 2;
          else m_t = 0;
        end
        default: begin m_mode = 0; m_en = 1'b0; end
      endcase
    end
  end

  // Delay-timer stub: fixed delay after each start, optional stale pulses, or free toggling
  int tm_delay = 10;
  bit tm_stale = 1'b0;
  bit tm_toggle = 1'b0;
  int tm_cnt = 0;

  always @(negedge clock) begin
    logic td;
    if (tm_toggle) begin
      timer_done = ~timer_done;
    end else begin
      td = 1'b0;
      if (tm_cnt > 0) begin
        tm_cnt = tm_cnt - 1;
        if (tm_cnt == 0) td = 1'b1;
      end
      if (timer_start) tm_cnt = tm_delay;
      if (tm_stale && $urandom_range(0, 15) == 0) td = 1'b1;
      timer_done = td;
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 30)
        $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Advance one cycle and compare every output against the model
  task automatic tick();
    @(negedge clock);
    #1;
    chk("step",        32'(step),        32'(m_mode == 1 && m_t < SH));
    chk("timer_start", 32'(timer_start), 32'(m_mode == 1 && m_t == SH));
    chk("done",        32'(done),        32'(m_mode == 2));
    chk("aborted",     32'(aborted),     32'(m_abt));
    chk("busy",        32'(busy),        32'(m_mode != 0));
    chk("cmd_ready",   32'(cmd_ready),   32'(m_mode == 0));
    chk("enable",      32'(enable),      32'(m_en));
    chk("dir",         32'(dir),         32'(m_dir));
    chk("steps_left",  32'(steps_left),  32'(m_left));
  endtask

  task automatic do_cmd(input logic d, input int n);
    cmd_valid = 1'b1;
    cmd_dir   = d;
    cmd_steps = SW'(n);
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic run_until_idle(input int budget, output int rises, output int ts,
                                output int dn, output int ab, output int minw, output int maxw);
    int   hl;
    logic prev;
    bit   fin;
    rises = 0; ts = 0; dn = 0; ab = 0; minw = 1000; maxw = 0; hl = 0; prev = 1'b0; fin = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (step && !prev) rises++;
      if (step) hl++;
      else if (prev) begin
        if (hl < minw) minw = hl;
        if (hl > maxw) maxw = hl;
        hl = 0;
      end
      if (timer_start) ts++;
      if (done) dn++;
      if (aborted) ab++;
      prev = step;
      if (!busy) begin fin = 1'b1; break; end
      tick();
    end
    if (!fin) chk("run_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    int r, t, d, a, mn, mx;
    bit found;
    logic prev;

    // Reset values
    repeat (3) tick();
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rst_steps_left", 32'(steps_left), 32'd0);
    chk("rst_enable", 32'(enable), 32'd0);
    reset_n = 1'b1;
    tick();

    // Normal 3-step move, timer delay 10
    tm_delay = 10;
    do_cmd(1'b1, 3);
    run_until_idle(1000, r, t, d, a, mn, mx);
    chk("norm_rises", 32'(r), 32'd3);
    chk("norm_timer_starts", 32'(t), 32'd3);
    chk("norm_done", 32'(d), 32'd1);
    chk("norm_aborted", 32'(a), 32'd0);
    chk("norm_min_width", 32'(mn), 32'd50);
    chk("norm_max_width", 32'(mx), 32'd50);
    chk("norm_dir", 32'(dir), 32'd1);
    chk("norm_enable_off", 32'(enable), 32'd0);
    chk("norm_left", 32'(steps_left), 32'd0);

    // Zero-step command
    do_cmd(1'b0, 0);
    chk("zero_done", 32'(done), 32'd1);
    chk("zero_step", 32'(step), 32'd0);
    chk("zero_ready_low", 32'(cmd_ready), 32'd0);
    tick();
    chk("zero_ready_back", 32'(cmd_ready), 32'd1);
    chk("zero_done_gone", 32'(done), 32'd0);
    chk("zero_timer", 32'(timer_start), 32'd0);

    // Timer done toggling every cycle
    tm_toggle = 1'b1;
    do_cmd(1'b0, 2);
    run_until_idle(1000, r, t, d, a, mn, mx);
    chk("tog_rises", 32'(r), 32'd2);
    chk("tog_timer_starts", 32'(t), 32'd2);
    chk("tog_done", 32'(d), 32'd1);

    // Abort in WAIT coincident with timer_done after two completed steps
    do_cmd(1'b1, 5);
    found = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      if (m_mode == 1 && m_t > SH && m_left == 3 && timer_done) begin found = 1'b1; break; end
      tick();
    end
    chk("abort_window_found", 32'(found), 32'd1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_pulse", 32'(aborted), 32'd1);
    chk("abort_no_done", 32'(done), 32'd0);
    chk("abort_left", 32'(steps_left), 32'd3);
    chk("abort_step", 32'(step), 32'd0);
    chk("abort_enable", 32'(enable), 32'd0);
    tm_toggle = 1'b0;
    tm_delay = 5;
    tick();
    do_cmd(1'b0, 1);
    run_until_idle(1000, r, t, d, a, mn, mx);
    chk("post_abort_done", 32'(d), 32'd1);
    chk("post_abort_rises", 32'(r), 32'd1);

    // Reset during STEP_HI of the second step
    tm_delay = 4;
    do_cmd(1'b1, 3);
    r = 1; prev = step;
    for (int i = 0; i < 500 && r < 2; i++) begin
      tick();
      if (step && !prev) r++;
      prev = step;
    end
    repeat (3) tick();
    chk("rst_mid_in_step", 32'(step), 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("rst_mid_step_drop", 32'(step), 32'd0);
    chk("rst_mid_enable_drop", 32'(enable), 32'd0);
    repeat (2) tick();
    reset_n = 1'b1;
    tick();
    chk("rst_mid_ready", 32'(cmd_ready), 32'd1);
    chk("rst_mid_left", 32'(steps_left), 32'd0);
    chk("rst_mid_done", 32'(done), 32'd0);

    // Back-to-back commands with cmd_valid held
    tm_delay = 3;
    cmd_valid = 1'b1; cmd_dir = 1'b0; cmd_steps = SW'(1);
    tick();
    cmd_dir = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 500; i++) begin
      if (cmd_ready) begin found = 1'b1; break; end
      tick();
    end
    chk("b2b_ready_seen", 32'(found), 32'd1);
    chk("b2b_dir_before", 32'(dir), 32'd0);
    tick();
    cmd_valid = 1'b0;
    chk("b2b_dir_after", 32'(dir), 32'd1);
    chk("b2b_second_step", 32'(step), 32'd1);
    run_until_idle(1000, r, t, d, a, mn, mx);
    chk("b2b_second_done", 32'(d), 32'd1);

    // Random traffic with stale timer pulses and sporadic aborts
    tm_stale = 1'b1;
    for (int i = 0; i < 6000; i++) begin
      cmd_valid = ($urandom_range(0, 3) == 0);
      cmd_dir   = 1'($urandom_range(0, 1));
      cmd_steps = SW'($urandom_range(0, 4));
      abort     = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 63) == 0) tm_delay = $urandom_range(1, 12);
      tick();
    end
    cmd_valid = 1'b0;
    abort = 1'b0;
    tm_stale = 1'b0;
    repeat (400) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/stepper_step_sequencer.md
Name: stepper_step_sequencer

Overview:
- Drives one stepper motor driver (STEP/DIR/ENABLE pins) through a commanded number of steps.
- Inter-step spacing comes from an external one-shot millisecond delay timer. This block is the initiator side of that interface: it pulses timer_start and consumes timer_done.
- Sits between the move planner (command handshake) and the motor driver pins.

Parameters:
- STEP_HIGH, 50: width of each step pulse in clock cycles; legal range 1..255.
- STEPS_W, 8: width of the step-count field.

Ports:
- clock  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  block can accept a command (high only in IDLE).
- cmd_dir  in  1  direction for the command.
- cmd_steps  in  STEPS_W  number of steps; 0 is legal.
- abort  in  1  cancel the current move.
- timer_start  out  1  one-cycle start pulse to the delay timer.
- timer_done  in  1  delay-timer expiry.
- step  out  1  driver STEP pin.
- dir  out  1  driver DIR pin; registered, held between moves.
- enable  out  1  driver ENABLE; high for the whole move.
- busy  out  1  high whenever state is not IDLE.
- steps_left  out  STEPS_W  remaining steps.
- done  out  1  one-cycle pulse when a move completes normally.
- aborted  out  1  one-cycle pulse when a move is cancelled.

Behaviour:
- Reset (async assert, clocked release): state IDLE.
  - Outputs at reset: step, dir, enable, busy, timer_start, done, aborted = 0; steps_left = 0; cmd_ready = 1.
  - Reset mid-move drops step and enable immediately.
- States: IDLE, STEP_HI, START, WAIT, FINISH.
- IDLE: accept on a clock edge with cmd_valid & cmd_ready & !abort.
  - At accept: latch dir <= cmd_dir and steps_left <= cmd_steps; set enable = 1.
  - cmd_steps = 0: go to FINISH; no step pulse and no timer use.
  - Otherwise: go to STEP_HI, set step = 1, load the high counter with STEP_HIGH-1.
- STEP_HI: step held high for exactly STEP_HIGH cycles, counted from the accept edge (or the re-entry edge). At count 0: step = 0, timer_start = 1, go to START.
- START: timer_start is high for exactly this one cycle. timer_done is ignored in this cycle because it may be stale from a previous delay. Go to WAIT next edge.
- WAIT: the first timer_done = 1 sampled here ends the delay.
  - steps_left decrements by 1 on that edge.
  - If the decremented value is 0: go to FINISH.
  - Otherwise: go to STEP_HI with step = 1.
  - The timer may keep asserting done on later cycles after its first pulse. Only the first sample in WAIT counts; the state leaves WAIT on that edge.
- FINISH: done = 1 for one cycle, enable = 0, return to IDLE. cmd_ready is high again on the following cycle.
- abort: sampled every cycle; takes priority over everything except reset.
  - In any non-IDLE state: next edge gives step = 0, enable = 0, timer_start = 0, aborted = 1 (one cycle), state IDLE.
  - steps_left keeps the remaining count for diagnostics until the next accept.
  - abort in IDLE has no effect and blocks acceptance of a simultaneous cmd_valid.
- Simultaneous events:
  - abort together with timer_done in WAIT: abort wins, no decrement, no done.
  - abort together with the FINISH cycle: done still pulses (move already complete), aborted stays 0.
- No counter wraps: steps_left never decrements below 0. The high counter is 8 bits.
- done and aborted are mutually exclusive and never both pulse for one move.
- Per-step period in cycles = STEP_HIGH + 1 (START) + timer latency.

Test Plan:
- Reset mid-move: cmd_steps=3, assert reset_n=0 during STEP_HI of step 2 -> step and enable drop asynchronously; after release state IDLE, cmd_ready=1, steps_left=0, no done.
- Normal move: cmd_dir=1, cmd_steps=3, stub timer pulses done 10 cycles after start -> 3 step pulses each exactly 50 cycles high, 3 timer_start pulses, steps_left 3->2->1->0, dir=1 throughout, single done pulse, enable low after done.
- Zero steps: cmd_steps=0 -> no step or timer_start; done pulses 1 cycle after accept; cmd_ready high 2 cycles after accept.
- Repeating timer done: stub holds timer_done toggling every cycle including the START cycle -> exactly one decrement per timer_start; 2-step move yields exactly 2 step pulses.
- Abort in WAIT with timer_done coincident, cmd_steps=5 after 2 completed steps -> aborted pulse, no done, steps_left=3, step=0, enable=0, then a new command is accepted normally.
- Back-to-back commands: cmd_valid held high with two queued commands of 1 step each (dir 0 then 1) -> second accepted the cycle after FINISH; dir changes only at the second accept.
